// File: rtl/para_encoder_seq_if.sv
// Handshake bundle between a request-vector producer and para_encoder_seq.
// Signals: in/enable/in_ready (load side), out/out_valid/out_ready/out_last (emit side),
//          zero_err (all-zero load indication).
interface para_encoder_seq_if #(
    parameter int in_width  = 4,
    parameter int out_width = 2
);
    logic [in_width-1:0]  in;
    logic                 enable;
    logic                 in_ready;
    logic [out_width-1:0] out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 zero_err;

    // master: the environment that loads vectors and consumes indices
    modport master (
        output in, enable, out_ready,
        input  in_ready, out, out_valid, out_last, zero_err
    );

    // slave: the encoder itself
    modport slave (
        input  in, enable, out_ready,
        output in_ready, out, out_valid, out_last, zero_err
    );
endinterface

// File: rtl/para_encoder_seq.sv
// Sequential priority encoder: loads a request vector, then emits the index of every
// set bit in ascending order, one per out_valid/out_ready handshake.
// Latency: first index valid the cycle after the load edge; one index per cycle when
// out_ready stays high. Backpressure: out/out_last/pend hold while out_ready is low;
// loads are refused (in_ready=0) until the last index has been taken.
// Ports: clk, rst_n (synchronous, active-low), bus (para_encoder_seq_if.slave).
module para_encoder_seq #(
    parameter int in_width  = 4,
    parameter int out_width = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    para_encoder_seq_if.slave  bus
);

    // Reject impossible geometries at elaboration time.
    if (in_width < 2 || in_width > (1 << out_width)) begin : g_bad_params
        $error("para_encoder_seq: need 2 <= in_width <= 2**out_width");
    end

    localparam logic [in_width-1:0] ONE = in_width'(1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t               state_q;
    logic [in_width-1:0]  pend_q;
    logic [out_width-1:0] out_q;
    logic                 out_last_q;
    logic                 zero_err_q;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic [in_width-1:0]  pend_d;

    // Index of the lowest set bit; 0 for an empty vector.
    function automatic logic [out_width-1:0] lowest_idx(input logic [in_width-1:0] v);
        logic [out_width-1:0] idx;
        idx = '0;
        for (int i = in_width - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = out_width'(i);
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic single_bit(input logic [in_width-1:0] v);
        return (v != '0) && ((v & (v - ONE)) == '0);
    endfunction

    // Pending vector with the currently presented index retired.
    always_comb begin
        pend_d = pend_q & ~(ONE << out_q);
    end

    // Outputs for the next index are precomputed here so every output is a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            out_q       <= '0;
            out_last_q  <= 1'b0;
            zero_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            zero_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        if (bus.in != '0) begin
                            pend_q      <= bus.in;
                            out_q       <= lowest_idx(bus.in);
                            out_last_q  <= single_bit(bus.in);
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= EMIT;
                        end else begin
                            zero_err_q <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // enable/in are deliberately not looked at here.
                    if (bus.out_ready) begin
                        pend_q <= pend_d;
                        if (out_last_q) begin
                            out_q       <= '0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            out_q      <= lowest_idx(pend_d);
                            out_last_q <= single_bit(pend_d);
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    pend_q      <= '0;
                    out_q       <= '0;
                    out_last_q  <= 1'b0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.out_last  = out_last_q;
    assign bus.zero_err  = zero_err_q;

endmodule

// File: tb/tb_para_encoder_seq.sv
module tb_para_encoder_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] din;
    logic       ordy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    para_encoder_seq_if #(.in_width(4), .out_width(2)) if4 ();
    para_encoder_seq_if #(.in_width(8), .out_width(3)) if8 ();

    assign if4.in        = din[3:0];
    assign if4.enable    = enable;
    assign if4.out_ready = ordy;
    assign if8.in        = din;
    assign if8.enable    = enable;
    assign if8.out_ready = ordy;

    para_encoder_seq #(.in_width(4), .out_width(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    para_encoder_seq #(.in_width(8), .out_width(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: the list of indices still owed to the consumer.
    int  q4[$];
    int  q8[$];
    bit  z4 = 1'b0;
    bit  z8 = 1'b0;
    bit  started = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_n) begin
            q4.delete(); q8.delete();
            z4 = 1'b0; z8 = 1'b0;
        end else begin
            z4 = 1'b0; z8 = 1'b0;
            if (q4.size() == 0) begin
                if (enable) begin
                    if (din[3:0] == 4'd0) z4 = 1'b1;
                    else for (int i = 0; i < 4; i++) if (din[i]) q4.push_back(i);
                end
            end else if (ordy) begin
                void'(q4.pop_front());
            end
            if (q8.size() == 0) begin
                if (enable) begin
                    if (din == 8'd0) z8 = 1'b1;
                    else for (int i = 0; i < 8; i++) if (din[i]) q8.push_back(i);
                end
            end else if (ordy) begin
                void'(q8.pop_front());
            end
        end
    end

    // Handshake log of the 4-bit instance, encoded as index*2 + last.
    int log4[$];
    always @(posedge clk) begin
        if (rst_n && if4.out_valid && ordy) log4.push_back(int'(if4.out) * 2 + int'(if4.out_last));
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("m4_valid", int'(if4.out_valid), (q4.size() != 0) ? 1 : 0);
            chk("m4_ready", int'(if4.in_ready),  (q4.size() == 0) ? 1 : 0);
            chk("m4_out",   int'(if4.out),       (q4.size() != 0) ? q4[0] : 0);
            chk("m4_last",  int'(if4.out_last),  (q4.size() == 1) ? 1 : 0);
            chk("m4_zerr",  int'(if4.zero_err),  int'(z4));
            chk("m8_valid", int'(if8.out_valid), (q8.size() != 0) ? 1 : 0);
            chk("m8_ready", int'(if8.in_ready),  (q8.size() == 0) ? 1 : 0);
            chk("m8_out",   int'(if8.out),       (q8.size() != 0) ? q8[0] : 0);
            chk("m8_last",  int'(if8.out_last),  (q8.size() == 1) ? 1 : 0);
            chk("m8_zerr",  int'(if8.zero_err),  int'(z8));
        end
    end

    task automatic cyc(input logic e, input logic [7:0] d, input logic r, input logic rs);
        enable = e; din = d; ordy = r; rst_n = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        enable = 1'b0; din = 8'd0; ordy = 1'b0; rst_n = 1'b0;
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        chk("rst_ready", int'(if4.in_ready), 1);
        chk("rst_valid", int'(if4.out_valid), 0);
        chk("rst_out",   int'(if4.out), 0);
        chk("rst_zerr",  int'(if4.zero_err), 0);

        // Defaults: 1011 -> 0,1,3
        log4.delete();
        cyc(1, 8'b0000_1011, 1, 1);
        chk("s1_lat_valid", int'(if4.out_valid), 1);
        chk("s1_out0", int'(if4.out), 0);
        cyc(0, 8'h00, 1, 1);
        chk("s1_out1", int'(if4.out), 1);
        cyc(0, 8'h00, 1, 1);
        chk("s1_out3", int'(if4.out), 3);
        chk("s1_last3", int'(if4.out_last), 1);
        cyc(0, 8'h00, 1, 1);
        chk("s1_idle_ready", int'(if4.in_ready), 1);
        chk("s1_n", log4.size(), 3);
        if (log4.size() == 3) begin
            chk("s1_h0", log4[0], 0);
            chk("s1_h1", log4[1], 2);
            chk("s1_h2", log4[2], 7);
        end

        // Back-pressure: 0110 held, then 1, 2
        log4.delete();
        cyc(1, 8'b0000_0110, 0, 1);
        for (int i = 0; i < 3; i++) begin
            chk("s2_hold_out", int'(if4.out), 1);
            chk("s2_hold_last", int'(if4.out_last), 0);
            cyc(0, 8'h00, 0, 1);
        end
        cyc(0, 8'h00, 1, 1);
        chk("s2_out2", int'(if4.out), 2);
        chk("s2_last2", int'(if4.out_last), 1);
        cyc(0, 8'h00, 1, 1);
        chk("s2_n", log4.size(), 2);
        if (log4.size() == 2) begin
            chk("s2_h0", log4[0], 2);
            chk("s2_h1", log4[1], 5);
        end

        // Zero load
        cyc(1, 8'h00, 1, 1);
        chk("s3_zerr", int'(if4.zero_err), 1);
        chk("s3_valid", int'(if4.out_valid), 0);
        chk("s3_ready", int'(if4.in_ready), 1);
        cyc(0, 8'h00, 1, 1);
        chk("s3_zerr_drop", int'(if4.zero_err), 0);

        // Load ignored while emitting 1000
        log4.delete();
        cyc(1, 8'b0000_1000, 0, 1);
        chk("s4_out3", int'(if4.out), 3);
        cyc(1, 8'b0000_1111, 1, 1);
        chk("s4_idle", int'(if4.out_valid), 0);
        cyc(0, 8'h00, 1, 1);
        chk("s4_still_idle", int'(if4.out_valid), 0);
        chk("s4_n", log4.size(), 1);

        // Reset mid-operation on 1111
        log4.delete();
        cyc(1, 8'b0000_1111, 1, 1);
        cyc(0, 8'h00, 1, 1);
        chk("s5_out1", int'(if4.out), 1);
        cyc(0, 8'h00, 1, 0);
        chk("s5_rst_valid", int'(if4.out_valid), 0);
        chk("s5_rst_ready", int'(if4.in_ready), 1);
        chk("s5_rst_out", int'(if4.out), 0);
        chk("s5_rst_last", int'(if4.out_last), 0);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 1);
        chk("s5_n", log4.size(), 1);

        // Wide instance: 1000_0001 -> 0 then 7
        cyc(1, 8'b1000_0001, 1, 1);
        chk("s6_out0", int'(if8.out), 0);
        chk("s6_last0", int'(if8.out_last), 0);
        cyc(0, 8'h00, 1, 1);
        chk("s6_out7", int'(if8.out), 7);
        chk("s6_last7", int'(if8.out_last), 1);
        cyc(0, 8'h00, 1, 1);

        // Random loads with random back-pressure, checked by the model each cycle.
        for (int n = 0; n < 25; n++) begin
            int w;
            cyc(1, 8'($urandom), 1'($urandom_range(0, 1)), 1);
            w = 0;
            while ((q4.size() != 0 || q8.size() != 0) && w < 60) begin
                cyc(0, 8'($urandom), 1'($urandom_range(0, 1)), 1);
                w++;
            end
            chk("rnd_drain", (q4.size() == 0 && q8.size() == 0) ? 1 : 0, 1);
            cyc(0, 8'h00, 1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
